// File: rtl/serial_bus_loader_if.sv
// Host-side signal bundle for the serial bus loader: UART byte streams plus
// the Z80 bus-request handshake and the memory strobes it drives as bus master.
interface serial_bus_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busrq_n;
   logic        busak_n;
   logic [15:0] addr;
   logic [7:0]  dout;
   logic [7:0]  din;
   logic        mreq_n;
   logic        rd_n;
   logic        wr_n;
   logic        overrun;

   modport master (
      input  rx_data, rx_valid, tx_ready, busak_n, din,
      output tx_data, tx_valid, busrq_n, addr, dout, mreq_n, rd_n, wr_n, overrun
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, busak_n, din,
      input  tx_data, tx_valid, busrq_n, addr, dout, mreq_n, rd_n, wr_n, overrun
   );
endinterface

// File: rtl/serial_bus_loader.sv
// Debug/load engine: parses UART command frames, takes the Z80 bus via
// BUSRQ/BUSAK and performs block memory reads or writes as bus master.
module serial_bus_loader #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TO_WIDTH       = 20
) (
   input  logic                clk,
   input  logic                reset_n,
   serial_bus_loader_if.master bus
);

   typedef enum logic [3:0] {
      IDLE, HDR_AH, HDR_AL, HDR_LEN, REQ, W_WAIT, W_STROBE,
      R_STROBE, R_CAPT, R_SEND, ACK, REL
   } state_e;

   localparam logic [7:0]          CMD_WR   = 8'h57;
   localparam logic [7:0]          CMD_RD   = 8'h52;
   localparam logic [7:0]          ACK_BYTE = 8'h4B;
   localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   state_e              state_q,    state_d;
   logic                is_wr_q,    is_wr_d;
   logic [15:0]         addr_q,     addr_d;
   logic [8:0]          count_q,    count_d;
   logic [7:0]          dout_q,     dout_d;
   logic [7:0]          buf_data_q, buf_data_d;
   logic                buf_full_q, buf_full_d;
   logic [7:0]          tx_data_q,  tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                busrq_n_q,  busrq_n_d;
   logic                mreq_n_q,   mreq_n_d;
   logic                rd_n_q,     rd_n_d;
   logic                wr_n_q,     wr_n_d;
   logic                overrun_q,  overrun_d;
   logic [TO_WIDTH-1:0] to_cnt_q,   to_cnt_d;

   logic to_run;
   logic to_expired;

   // NOTE: every always_comb output gets a default first so no path leaves
   // a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      addr_d     = addr_q;
      count_d    = count_q;
      dout_d     = dout_q;
      buf_data_d = buf_data_q;
      buf_full_d = buf_full_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      overrun_d  = overrun_q;

      // The inter-byte timer only runs while the frame is waiting on the host.
      to_run     = (state_q inside {HDR_AH, HDR_AL, HDR_LEN}) ||
                   (state_q == W_WAIT && !buf_full_q);
      to_expired = to_run && !bus.rx_valid && (to_cnt_q == TO_LAST);
      to_cnt_d   = (to_run && !bus.rx_valid && !to_expired) ? to_cnt_q + 1'b1 : '0;

      // Write data that arrives before the engine can use it parks in the
      // one-byte buffer; a second early byte is lost and flagged.
      if (bus.rx_valid && is_wr_q && (state_q inside {REQ, W_STROBE})) begin
         if (buf_full_q) begin
            overrun_d = 1'b1;
         end else begin
            buf_data_d = bus.rx_data;
            buf_full_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            buf_full_d = 1'b0;
            if (bus.rx_valid && (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD)) begin
               is_wr_d = (bus.rx_data == CMD_WR);
               state_d = HDR_AH;
            end
         end
         HDR_AH: begin
            if (bus.rx_valid) begin
               addr_d[15:8] = bus.rx_data;
               state_d      = HDR_AL;
            end else if (to_expired) begin
               state_d = IDLE;
            end
         end
         HDR_AL: begin
            if (bus.rx_valid) begin
               addr_d[7:0] = bus.rx_data;
               state_d     = HDR_LEN;
            end else if (to_expired) begin
               state_d = IDLE;
            end
         end
         HDR_LEN: begin
            if (bus.rx_valid) begin
               // A zero length byte encodes a full 256-byte block.
               count_d = {(bus.rx_data == 8'h00), bus.rx_data};
               state_d = REQ;
            end else if (to_expired) begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (!bus.busak_n) begin
               state_d = is_wr_q ? W_WAIT : R_STROBE;
            end
         end
         W_WAIT: begin
            if (buf_full_q) begin
               if (bus.rx_valid) begin
                  overrun_d = 1'b1;
               end
               if (!bus.busak_n) begin
                  dout_d     = buf_data_q;
                  buf_full_d = 1'b0;
                  state_d    = W_STROBE;
               end
            end else if (bus.rx_valid) begin
               if (!bus.busak_n) begin
                  dout_d  = bus.rx_data;
                  state_d = W_STROBE;
               end else begin
                  buf_data_d = bus.rx_data;
                  buf_full_d = 1'b1;
               end
            end else if (to_expired) begin
               state_d = REL;
            end
         end
         W_STROBE: begin
            addr_d  = addr_q + 16'd1;
            count_d = count_q - 9'd1;
            if (count_q == 9'd1) begin
               tx_data_d  = ACK_BYTE;
               tx_valid_d = 1'b1;
               state_d    = ACK;
            end else begin
               state_d = W_WAIT;
            end
         end
         R_STROBE: begin
            // Stays here with strobes idle while the CPU holds the bus back.
            if (!rd_n_q) begin
               state_d = R_CAPT;
            end
         end
         R_CAPT: begin
            tx_data_d  = bus.din;
            tx_valid_d = 1'b1;
            addr_d     = addr_q + 16'd1;
            count_d    = count_q - 9'd1;
            state_d    = R_SEND;
         end
         R_SEND: begin
            if (bus.tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = (count_q == 9'd0) ? REL : R_STROBE;
            end
         end
         ACK: begin
            if (bus.tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = REL;
            end
         end
         REL: begin
            if (bus.busak_n) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Strobes and the bus request are decoded from the next state so they
      // leave a flop cleanly, aligned with the state they belong to.
      wr_n_d    = (state_d != W_STROBE);
      rd_n_d    = !(state_d == R_STROBE && !bus.busak_n);
      mreq_n_d  = wr_n_d && rd_n_d;
      busrq_n_d = !(state_d inside {REQ, W_WAIT, W_STROBE, R_STROBE, R_CAPT, R_SEND, ACK});
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge value of every other flop regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         is_wr_q    <= 1'b0;
         addr_q     <= '0;
         count_q    <= '0;
         dout_q     <= '0;
         buf_data_q <= '0;
         buf_full_q <= 1'b0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busrq_n_q  <= 1'b1;
         mreq_n_q   <= 1'b1;
         rd_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         overrun_q  <= 1'b0;
         to_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         is_wr_q    <= is_wr_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         dout_q     <= dout_d;
         buf_data_q <= buf_data_d;
         buf_full_q <= buf_full_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busrq_n_q  <= busrq_n_d;
         mreq_n_q   <= mreq_n_d;
         rd_n_q     <= rd_n_d;
         wr_n_q     <= wr_n_d;
         overrun_q  <= overrun_d;
         to_cnt_q   <= to_cnt_d;
      end
   end

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.busrq_n  = busrq_n_q;
   assign bus.addr     = addr_q;
   assign bus.dout     = dout_q;
   assign bus.mreq_n   = mreq_n_q;
   assign bus.rd_n     = rd_n_q;
   assign bus.wr_n     = wr_n_q;
   assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_serial_bus_loader.sv
// Directed bench for serial_bus_loader with a CPU bus-grant model, a
// synchronous memory model and a UART transmitter model.
module tb_serial_bus_loader;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   serial_bus_loader_if bus ();

   serial_bus_loader #(.TIMEOUT_CYCLES(40), .TO_WIDTH(20)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // CPU grants the bus four cycles after the request and releases promptly.
   int ak_cnt;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.busak_n <= 1'b1;
         ak_cnt      <= 0;
      end else if (!bus.busrq_n) begin
         if (ak_cnt >= 3) bus.busak_n <= 1'b0;
         else             ak_cnt      <= ak_cnt + 1;
      end else begin
         bus.busak_n <= 1'b1;
         ak_cnt      <= 0;
      end
   end

   logic [7:0] mem [65536];
   always @(posedge clk) begin
      if (!bus.mreq_n && !bus.wr_n) mem[bus.addr] <= bus.dout;
   end
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)                      bus.din <= 8'h00;
      else if (!bus.mreq_n && !bus.rd_n) bus.din <= mem[bus.addr];
   end

   int tx_delay;
   int tx_wait;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.tx_ready <= 1'b0;
         tx_wait      <= 0;
      end else if (bus.tx_valid && bus.tx_ready) begin
         bus.tx_ready <= 1'b0;
         tx_wait      <= 0;
      end else if (bus.tx_valid) begin
         if (tx_wait >= tx_delay) bus.tx_ready <= 1'b1;
         else                     tx_wait      <= tx_wait + 1;
      end
   end

   // Bus monitor: logs every strobe cycle and transmitted byte.
   logic [7:0]  tx_log      [1024];
   logic [15:0] wr_addr_log [1024];
   logic [7:0]  wr_data_log [1024];
   logic [15:0] rd_addr_log [1024];
   int tx_n, wr_cnt, rd_cnt, viol_cnt, drop_cnt, rq_cycles;
   logic prev_v, prev_r;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_n <= 0; wr_cnt <= 0; rd_cnt <= 0; viol_cnt <= 0; drop_cnt <= 0; rq_cycles <= 0;
         prev_v <= 1'b0; prev_r <= 1'b0;
      end else begin
         if (bus.tx_valid && bus.tx_ready) begin
            tx_log[tx_n[9:0]] <= bus.tx_data;
            tx_n <= tx_n + 1;
         end
         if (!bus.wr_n) begin
            wr_addr_log[wr_cnt[9:0]] <= bus.addr;
            wr_data_log[wr_cnt[9:0]] <= bus.dout;
            wr_cnt <= wr_cnt + 1;
         end
         if (!bus.rd_n) begin
            rd_addr_log[rd_cnt[9:0]] <= bus.addr;
            rd_cnt <= rd_cnt + 1;
         end
         if ((!bus.rd_n && !bus.wr_n) ||
             (!(bus.rd_n && bus.wr_n) && (bus.mreq_n || bus.busak_n)))
            viol_cnt <= viol_cnt + 1;
         if (prev_v && !prev_r && !bus.tx_valid) drop_cnt <= drop_cnt + 1;
         if (!bus.busrq_n) rq_cycles <= rq_cycles + 1;
         prev_v <= bus.tx_valid;
         prev_r <= bus.tx_ready;
      end
   end

   int n_pass   = 0;
   int n_checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] a, input logic [7:0] len);
      send(cmd, 1);
      send(a[15:8], 1);
      send(a[7:0], 1);
      send(len, 1);
   endtask

   task automatic wait_ak(input string tag);
      for (int i = 0; i < 100 && bus.busak_n; i++) @(negedge clk);
      check(tag, bus.busak_n, 1'b0);
      tick(2);
   endtask

   task automatic wait_tx(input string tag, input int target);
      for (int i = 0; i < 400 && tx_n < target; i++) @(negedge clk);
      check(tag, tx_n, target);
   endtask

   task automatic wait_rel(input string tag);
      for (int i = 0; i < 100 && !(bus.busrq_n && bus.busak_n); i++) @(negedge clk);
      check(tag, {bus.busrq_n, bus.busak_n}, 2'b11);
      tick(2);
   endtask

   int bw, bt, br, brq;

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      tx_delay     = 0;
      reset_n      = 1'b0;
      tick(3);
      check("rst_busrq_n",  bus.busrq_n,  1'b1);
      check("rst_mreq_n",   bus.mreq_n,   1'b1);
      check("rst_rd_n",     bus.rd_n,     1'b1);
      check("rst_wr_n",     bus.wr_n,     1'b1);
      check("rst_tx_valid", bus.tx_valid, 1'b0);
      check("rst_tx_data",  bus.tx_data,  8'h00);
      check("rst_addr",     bus.addr,     16'h0000);
      check("rst_dout",     bus.dout,     8'h00);
      check("rst_overrun",  bus.overrun,  1'b0);
      reset_n = 1'b1;
      tick(2);

      // Two-byte write at 0x8000.
      bw = wr_cnt; bt = tx_n;
      send_hdr(8'h57, 16'h8000, 8'h02);
      wait_ak("w1_busak");
      send(8'hAA, 3);
      send(8'h55, 3);
      wait_tx("w1_tx_cnt", bt + 1);
      check("w1_ack", tx_log[bt], 8'h4B);
      wait_rel("w1_release");
      check("w1_wr_cnt", wr_cnt - bw, 2);
      check("w1_addr0", wr_addr_log[bw],     16'h8000);
      check("w1_data0", wr_data_log[bw],     8'hAA);
      check("w1_addr1", wr_addr_log[bw + 1], 16'h8001);
      check("w1_data1", wr_data_log[bw + 1], 8'h55);

      // Preload 0x2000/0x2001, then read them back with a slow transmitter.
      bt = tx_n;
      send_hdr(8'h57, 16'h2000, 8'h02);
      wait_ak("pre_busak");
      send(8'h11, 3);
      send(8'h22, 3);
      wait_tx("pre_tx_cnt", bt + 1);
      wait_rel("pre_release");
      tx_delay = 10;
      bt = tx_n; br = rd_cnt;
      send_hdr(8'h52, 16'h2000, 8'h02);
      wait_tx("r1_tx_cnt", bt + 2);
      wait_rel("r1_release");
      check("r1_byte0", tx_log[bt],     8'h11);
      check("r1_byte1", tx_log[bt + 1], 8'h22);
      check("r1_rd_cnt", rd_cnt - br, 2);
      check("r1_addr0", rd_addr_log[br],     16'h2000);
      check("r1_addr1", rd_addr_log[br + 1], 16'h2001);
      tx_delay = 0;

      // Address wrap on both write and read.
      bw = wr_cnt; bt = tx_n;
      send_hdr(8'h57, 16'hFFFF, 8'h02);
      wait_ak("wrap_w_busak");
      send(8'hC3, 3);
      send(8'h3C, 3);
      wait_tx("wrap_w_tx_cnt", bt + 1);
      wait_rel("wrap_w_release");
      check("wrap_w_addr0", wr_addr_log[bw],     16'hFFFF);
      check("wrap_w_addr1", wr_addr_log[bw + 1], 16'h0000);
      bt = tx_n; br = rd_cnt;
      send_hdr(8'h52, 16'hFFFF, 8'h02);
      wait_tx("wrap_r_tx_cnt", bt + 2);
      wait_rel("wrap_r_release");
      check("wrap_r_addr0", rd_addr_log[br],     16'hFFFF);
      check("wrap_r_addr1", rd_addr_log[br + 1], 16'h0000);
      check("wrap_r_byte0", tx_log[bt],     8'hC3);
      check("wrap_r_byte1", tx_log[bt + 1], 8'h3C);

      // LEN=0 writes a full 256-byte block.
      bw = wr_cnt; bt = tx_n;
      send_hdr(8'h57, 16'h3000, 8'h00);
      wait_ak("len0_busak");
      for (int i = 0; i < 256; i++) send(8'(i), 2);
      wait_tx("len0_tx_cnt", bt + 1);
      wait_rel("len0_release");
      check("len0_wr_cnt", wr_cnt - bw, 256);
      check("len0_first_addr", wr_addr_log[bw],       16'h3000);
      check("len0_last_addr",  wr_addr_log[bw + 255], 16'h30FF);
      check("len0_last_data",  wr_data_log[bw + 255], 8'hFF);
      check("len0_ack", tx_log[bt], 8'h4B);

      // Header abandoned after silence; next 0x52 starts a fresh frame.
      brq = rq_cycles;
      send(8'h57, 1);
      send(8'h12, 1);
      tick(60);
      check("hto_no_busrq", rq_cycles - brq, 0);
      bt = tx_n; br = rd_cnt;
      send_hdr(8'h52, 16'h0010, 8'h01);
      wait_tx("hto_tx_cnt", bt + 1);
      wait_rel("hto_release");
      check("hto_rd_cnt", rd_cnt - br, 1);
      check("hto_rd_addr", rd_addr_log[br], 16'h0010);

      // Data timeout mid-write: one byte kept, bus released, no ACK.
      bw = wr_cnt; bt = tx_n;
      send_hdr(8'h57, 16'h4000, 8'h03);
      wait_ak("wto_busak");
      send(8'h99, 1);
      tick(80);
      check("wto_wr_cnt", wr_cnt - bw, 1);
      check("wto_addr", wr_addr_log[bw], 16'h4000);
      check("wto_data", wr_data_log[bw], 8'h99);
      check("wto_no_ack", tx_n - bt, 0);
      check("wto_released", {bus.busrq_n, bus.busak_n}, 2'b11);
      check("wto_overrun", bus.overrun, 1'b0);

      // Junk command ignored; back-to-back data overruns the buffer.
      bw = wr_cnt; bt = tx_n;
      send(8'h00, 1);
      send_hdr(8'h57, 16'h5000, 8'h02);
      wait_ak("b2b_busak");
      @(negedge clk);
      bus.rx_data = 8'hA1; bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_data = 8'hB2;
      @(negedge clk);
      bus.rx_data = 8'hC3;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      wait_tx("b2b_tx_cnt", bt + 1);
      wait_rel("b2b_release");
      check("b2b_wr_cnt", wr_cnt - bw, 2);
      check("b2b_addr0", wr_addr_log[bw],     16'h5000);
      check("b2b_data0", wr_data_log[bw],     8'hA1);
      check("b2b_addr1", wr_addr_log[bw + 1], 16'h5001);
      check("b2b_data1", wr_data_log[bw + 1], 8'hB2);
      check("b2b_overrun", bus.overrun, 1'b1);
      check("b2b_ack", tx_log[bt], 8'h4B);

      check("bus_violations", viol_cnt, 0);
      check("tx_valid_drops", drop_cnt, 0);

      // Reset while a read byte waits in R_SEND.
      tx_delay = 60;
      send_hdr(8'h52, 16'h2000, 8'h02);
      for (int i = 0; i < 100 && !bus.tx_valid; i++) @(negedge clk);
      check("mid_tx_valid", bus.tx_valid, 1'b1);
      tick(3);
      reset_n = 1'b0;
      #1;
      check("mid_rst_busrq_n",  bus.busrq_n,  1'b1);
      check("mid_rst_mreq_n",   bus.mreq_n,   1'b1);
      check("mid_rst_rd_n",     bus.rd_n,     1'b1);
      check("mid_rst_wr_n",     bus.wr_n,     1'b1);
      check("mid_rst_tx_valid", bus.tx_valid, 1'b0);
      check("mid_rst_overrun",  bus.overrun,  1'b0);
      tick(2);
      reset_n = 1'b1;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
